// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one memory port between two masters.
// Memory strobes are registered; read data is captured after READ_LATENCY cycles.
module mem_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   output logic                  m0_ack,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  m1_ack,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic [DATA_WIDTH-1:0] mem_write_data,
   input  logic [DATA_WIDTH-1:0] mem_read_data,
   output logic                  busy,
   output logic                  owner
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_GRANT  = 3'd1;
   localparam logic [2:0] S_ACCESS = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

   logic [2:0]            r_state;
   logic [2:0]            w_state_nxt;
   logic [2:0]            r_lat_cnt;
   logic                  r_we;
   logic                  r_owner;
   logic                  r_last_grant;
   logic                  r_mem_read;
   logic                  r_mem_write;
   logic [ADDR_WIDTH-1:0] r_mem_address;
   logic [DATA_WIDTH-1:0] r_mem_write_data;
   logic [DATA_WIDTH-1:0] r_m0_rdata;
   logic [DATA_WIDTH-1:0] r_m1_rdata;
   logic                  r_m0_ack;
   logic                  r_m1_ack;

   logic                  w_any_req;
   logic                  w_winner;
   logic                  w_win_we;
   logic [ADDR_WIDTH-1:0] w_win_addr;
   logic [DATA_WIDTH-1:0] w_win_wdata;
   logic                  w_lat_done;
   logic                  w_enter_done;
   logic                  w_start;

   // On a tie the master that did not win last time is served.
   assign w_any_req   = m0_req | m1_req;
   assign w_winner    = (m0_req & m1_req) ? ~r_last_grant : m1_req;
   assign w_win_we    = w_winner ? m1_we    : m0_we;
   assign w_win_addr  = w_winner ? m1_addr  : m0_addr;
   assign w_win_wdata = w_winner ? m1_wdata : m0_wdata;

   assign w_start      = (r_state == S_IDLE) & w_any_req;
   assign w_lat_done   = (r_lat_cnt == LAT_LAST);
   assign w_enter_done = (w_state_nxt == S_DONE) & (r_state != S_DONE);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_any_req) w_state_nxt = S_GRANT;
         S_GRANT:  w_state_nxt = S_ACCESS;
         S_ACCESS: w_state_nxt = r_we ? S_DONE : S_WAIT;
         S_WAIT:   if (w_lat_done) w_state_nxt = S_DONE;
         S_DONE:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_owner          <= 1'b0;
         r_last_grant     <= 1'b1;
         r_we             <= 1'b0;
         r_mem_address    <= '0;
         r_mem_write_data <= '0;
      end else if (w_start) begin
         r_owner          <= w_winner;
         r_last_grant     <= w_winner;
         r_we             <= w_win_we;
         r_mem_address    <= w_win_addr;
         r_mem_write_data <= w_win_wdata;
      end
   end

   // Strobes are set leaving GRANT so they are high for ACCESS only.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
      end else begin
         r_mem_read  <= (r_state == S_GRANT) & ~r_we;
         r_mem_write <= (r_state == S_GRANT) & r_we;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_lat_cnt <= 3'd0;
      end else if (r_state == S_ACCESS) begin
         r_lat_cnt <= 3'd0;
      end else if (r_state == S_WAIT) begin
         r_lat_cnt <= r_lat_cnt + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_m0_rdata <= '0;
         r_m1_rdata <= '0;
      end else if ((r_state == S_WAIT) && w_lat_done) begin
         if (r_owner) r_m1_rdata <= mem_read_data;
         else         r_m0_rdata <= mem_read_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_m0_ack <= 1'b0;
         r_m1_ack <= 1'b0;
      end else begin
         r_m0_ack <= w_enter_done & ~r_owner;
         r_m1_ack <= w_enter_done & r_owner;
      end
   end

   assign m0_rdata       = r_m0_rdata;
   assign m1_rdata       = r_m1_rdata;
   assign m0_ack         = r_m0_ack;
   assign m1_ack         = r_m1_ack;
   assign mem_read       = r_mem_read;
   assign mem_write      = r_mem_write;
   assign mem_address    = r_mem_address;
   assign mem_write_data = r_mem_write_data;
   assign busy           = (r_state != S_IDLE);
   assign owner          = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (READ_LATENCY 1 and 3) behind one
// set of master drivers, directed vectors plus a randomized model check.
module tb_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        sel;
   logic        mem_init;
   logic        d_req [2];
   logic        d_we [2];
   logic [31:0] d_addr [2];
   logic [31:0] d_wdata [2];

   logic        req_i [2][2];
   logic        we_i [2][2];
   logic [31:0] addr_i [2][2];
   logic [31:0] wdata_i [2][2];

   logic [31:0] rd_o [2][2];
   logic        ack_o [2][2];
   logic        mrd [2];
   logic        mwr [2];
   logic [31:0] maddr [2];
   logic [31:0] mwdata [2];
   logic [31:0] mrdata [2];
   logic        busy_o [2];
   logic        own_o [2];

   logic [31:0] mem [2][32];
   logic [31:0] pipe [2][3];

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_rd [2][2];

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 2; j++) begin
            req_i[i][j]   = (int'(sel) == i) && d_req[j];
            we_i[i][j]    = d_we[j];
            addr_i[i][j]  = d_addr[j];
            wdata_i[i][j] = d_wdata[j];
         end
      end
   end

   mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .m0_req(req_i[0][0]), .m0_we(we_i[0][0]),
      .m0_addr(addr_i[0][0]), .m0_wdata(wdata_i[0][0]),
      .m0_rdata(rd_o[0][0]), .m0_ack(ack_o[0][0]),
      .m1_req(req_i[0][1]), .m1_we(we_i[0][1]),
      .m1_addr(addr_i[0][1]), .m1_wdata(wdata_i[0][1]),
      .m1_rdata(rd_o[0][1]), .m1_ack(ack_o[0][1]),
      .mem_read(mrd[0]), .mem_write(mwr[0]),
      .mem_address(maddr[0]), .mem_write_data(mwdata[0]),
      .mem_read_data(mrdata[0]), .busy(busy_o[0]), .owner(own_o[0])
   );

   mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .READ_LATENCY(3)) u_dut3 (
      .clk(clk), .reset(reset),
      .m0_req(req_i[1][0]), .m0_we(we_i[1][0]),
      .m0_addr(addr_i[1][0]), .m0_wdata(wdata_i[1][0]),
      .m0_rdata(rd_o[1][0]), .m0_ack(ack_o[1][0]),
      .m1_req(req_i[1][1]), .m1_we(we_i[1][1]),
      .m1_addr(addr_i[1][1]), .m1_wdata(wdata_i[1][1]),
      .m1_rdata(rd_o[1][1]), .m1_ack(ack_o[1][1]),
      .mem_read(mrd[1]), .mem_write(mwr[1]),
      .mem_address(maddr[1]), .mem_write_data(mwdata[1]),
      .mem_read_data(mrdata[1]), .busy(busy_o[1]), .owner(own_o[1])
   );

   // Memory models: data shows up READ_LATENCY cycles after the strobe,
   // garbage otherwise so a mistimed capture is visible.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (mem_init) begin
            for (int a = 0; a < 32; a++) mem[i][a] <= 32'hA5A50000 | a;
         end else if (mwr[i]) begin
            mem[i][maddr[i][4:0]] <= mwdata[i];
         end
         pipe[i][0] <= mrd[i] ? mem[i][maddr[i][4:0]] : $urandom;
         pipe[i][1] <= pipe[i][0];
         pipe[i][2] <= pipe[i][1];
      end
   end
   assign mrdata[0] = pipe[0][0];
   assign mrdata[1] = pipe[1][2];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      int          s;
      int          m;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t tbl [8];

   task automatic run_txn(input vec_t v);
      bit got = 0;
      int o = 1 - v.m;
      sel = v.s[0];
      d_req[v.m] = 1'b1;
      d_we[v.m] = v.we;
      d_addr[v.m] = v.addr;
      d_wdata[v.m] = v.wdata;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         chk("other_ack", 64'(ack_o[v.s][o]), 64'd0);
         chk("mem_read", 64'(mrd[v.s]), 64'((k == 2) && !v.we));
         chk("mem_write", 64'(mwr[v.s]), 64'((k == 2) && v.we));
         if (k == 2) begin
            chk("mem_address", 64'(maddr[v.s]), 64'(v.addr));
            if (v.we) chk("mem_wdata", 64'(mwdata[v.s]), 64'(v.wdata));
         end
         if (ack_o[v.s][v.m]) begin
            chk("ack_latency", 64'(k), 64'(v.lat));
            if (!v.we) begin
               exp_rd[v.s][v.m] = v.exp;
               chk("rdata", 64'(rd_o[v.s][v.m]), 64'(v.exp));
            end
            chk("other_rdata", 64'(rd_o[v.s][o]), 64'(exp_rd[v.s][o]));
            d_req[v.m] = 1'b0;
            got = 1;
            break;
         end
      end
      if (!got) chk("ack_timeout", 64'd0, 64'd1);
      @(negedge clk);
      chk("ack_single", 64'(ack_o[v.s][v.m]), 64'd0);
      chk("idle_busy", 64'(busy_o[v.s]), 64'd0);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b0;
      d_req[0] = 1'b0;
      d_req[1] = 1'b0;
      repeat (n) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) exp_rd[i][j] = '0;
   endtask

   // Transaction-level reference: one grant at a time, fixed latencies.
   task automatic random_phase(input int s, input int cycles);
      int          rl = (s == 1) ? 3 : 1;
      int          m_free = 0, m_acc = -1, m_ack = -1;
      logic        m_last = 1'b1, m_own = 1'b0, m_we = 1'b0;
      logic [31:0] m_addr = '0, m_wdata = '0, m_rdv = '0;
      logic [31:0] m_rd [2];
      logic [31:0] ref_mem [32];
      int          w;
      sel = s[0];
      do_reset(2);
      m_rd[0] = '0;
      m_rd[1] = '0;
      for (int a = 0; a < 32; a++) ref_mem[a] = mem[s][a];
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (c == m_ack && !m_we) m_rd[m_own] = m_rdv;
         chk("r_busy", 64'(busy_o[s]), 64'(c < m_free));
         chk("r_mem_read", 64'(mrd[s]), 64'(c == m_acc && !m_we));
         chk("r_mem_write", 64'(mwr[s]), 64'(c == m_acc && m_we));
         if (c == m_acc) begin
            chk("r_mem_address", 64'(maddr[s]), 64'(m_addr));
            if (m_we) chk("r_mem_wdata", 64'(mwdata[s]), 64'(m_wdata));
         end
         chk("r_owner", 64'(own_o[s]), 64'(m_own));
         for (int j = 0; j < 2; j++) begin
            chk("r_ack", 64'(ack_o[s][j]),
                64'(c == m_ack && int'(m_own) == j));
            chk("r_rdata", 64'(rd_o[s][j]), 64'(m_rd[j]));
         end
         for (int j = 0; j < 2; j++) begin
            if (c == m_ack && int'(m_own) == j) d_req[j] = 1'b0;
            if (!d_req[j] && $urandom_range(2) == 0) begin
               d_req[j] = 1'b1;
               d_we[j] = 1'($urandom_range(1));
               d_addr[j] = 32'($urandom_range(31));
               d_wdata[j] = $urandom;
            end
         end
         if (c >= m_free && (d_req[0] || d_req[1])) begin
            if (d_req[0] && d_req[1]) w = m_last ? 0 : 1;
            else w = d_req[1] ? 1 : 0;
            m_last = w[0];
            m_own = w[0];
            m_we = d_we[w];
            m_addr = d_addr[w];
            m_wdata = d_wdata[w];
            m_acc = c + 2;
            m_ack = c + 3 + (m_we ? 0 : rl);
            m_free = m_ack + 1;
            if (m_we) ref_mem[m_addr[4:0]] = m_wdata;
            else m_rdv = ref_mem[m_addr[4:0]];
         end
      end
      d_req[0] = 1'b0;
      d_req[1] = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      int n;
      int last_k;
      int acks;
      logic pa;

      tbl[0] = '{0, 0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 3};
      tbl[1] = '{0, 1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 4};
      tbl[2] = '{0, 1, 1'b1, 32'h04, 32'h12345678, 32'h0, 3};
      tbl[3] = '{0, 0, 1'b0, 32'h04, 32'h0, 32'h12345678, 4};
      tbl[4] = '{0, 0, 1'b0, 32'h05, 32'h0, 32'hA5A50005, 4};
      tbl[5] = '{1, 0, 1'b1, 32'h08, 32'hCAFEF00D, 32'h0, 3};
      tbl[6] = '{1, 0, 1'b0, 32'h08, 32'h0, 32'hCAFEF00D, 6};
      tbl[7] = '{1, 1, 1'b0, 32'h10, 32'h0, 32'hA5A50010, 6};

      sel = 1'b0;
      mem_init = 1'b1;
      for (int j = 0; j < 2; j++) begin
         d_we[j] = 1'b0;
         d_addr[j] = '0;
         d_wdata[j] = '0;
      end
      do_reset(3);
      mem_init = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst_busy", 64'(busy_o[i]), 64'd0);
         chk("rst_owner", 64'(own_o[i]), 64'd0);
         chk("rst_strobe", 64'(mrd[i] | mwr[i]), 64'd0);
         chk("rst_maddr", 64'(maddr[i]), 64'd0);
         chk("rst_rdata", 64'(rd_o[i][0] | rd_o[i][1]), 64'd0);
         chk("rst_ack", 64'(ack_o[i][0] | ack_o[i][1]), 64'd0);
      end

      for (int t = 0; t < 8; t++) run_txn(tbl[t]);

      // Reset while the RL=3 instance sits in WAIT.
      sel = 1'b1;
      d_req[0] = 1'b1;
      d_we[0] = 1'b0;
      d_addr[0] = 32'h3;
      repeat (4) @(negedge clk);
      chk("pre_rst_busy", 64'(busy_o[1]), 64'd1);
      reset = 1'b0;
      d_req[0] = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("inrst_busy", 64'(busy_o[1]), 64'd0);
         chk("inrst_strobe", 64'(mrd[1] | mwr[1]), 64'd0);
         chk("inrst_ack", 64'(ack_o[1][0] | ack_o[1][1]), 64'd0);
      end
      reset = 1'b1;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 2; j++) exp_rd[i][j] = '0;
      repeat (8) begin
         @(negedge clk);
         chk("post_rst_ack", 64'(ack_o[1][0] | ack_o[1][1]), 64'd0);
         chk("post_rst_busy", 64'(busy_o[1]), 64'd0);
         chk("post_rst_rdata0", 64'(rd_o[1][0]), 64'd0);
         chk("post_rst_rdata1", 64'(rd_o[1][1]), 64'd0);
         chk("post_rst_owner", 64'(own_o[1]), 64'd0);
      end
      chk("post_rst_rdata_i1", 64'(rd_o[0][0] | rd_o[0][1]), 64'd0);

      // Both masters request continuously straight out of reset.
      sel = 1'b0;
      do_reset(2);
      for (int j = 0; j < 2; j++) begin
         d_req[j] = 1'b1;
         d_we[j] = 1'b1;
         d_addr[j] = 32'(20 + j);
         d_wdata[j] = 32'h1000 + 32'(j);
      end
      n = 0;
      last_k = 0;
      for (int k = 1; k <= 40 && n < 4; k++) begin
         @(negedge clk);
         chk("rr_both_ack", 64'(ack_o[0][0] & ack_o[0][1]), 64'd0);
         if (ack_o[0][0] || ack_o[0][1]) begin
            chk("rr_order", 64'(ack_o[0][1]), 64'(n % 2));
            chk("rr_owner", 64'(own_o[0]), 64'(n % 2));
            if (n > 0) chk("rr_spacing", 64'(k - last_k), 64'd4);
            last_k = k;
            n++;
            if (n == 4) begin
               d_req[0] = 1'b0;
               d_req[1] = 1'b0;
            end
         end
      end
      chk("rr_count", 64'(n), 64'd4);
      d_req[0] = 1'b0;
      d_req[1] = 1'b0;
      repeat (6) @(negedge clk);
      chk("rr_idle", 64'(busy_o[0]), 64'd0);

      // m0 lets go of req after grant; the write must still finish.
      d_req[0] = 1'b1;
      d_we[0] = 1'b1;
      d_addr[0] = 32'h6;
      d_wdata[0] = 32'h600D600D;
      acks = 0;
      last_k = 0;
      pa = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 2) d_req[0] = 1'b0;
         if (ack_o[0][0]) begin
            acks++;
            last_k = k;
         end
         pa = pa | ack_o[0][1];
      end
      chk("drop_acks", 64'(acks), 64'd1);
      chk("drop_ack_cycle", 64'(last_k), 64'd3);
      chk("drop_other_ack", 64'(pa), 64'd0);
      run_txn('{0, 1, 1'b0, 32'h6, 32'h0, 32'h600D600D, 4});

      random_phase(0, 500);
      random_phase(1, 500);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master, single-port arbiter that shares the unified instruction/data Memory between the Core (master 0) and the Controller_Test readback path (master 1).
- Replaces hard-wired option-based muxing with a req/ack handshake, round-robin fairness and registered memory-side strobes.
- Sits between both masters and the Memory port; the Memory keeps its existing read-latency behaviour.

Parameters:
- ADDR_WIDTH, 32, address width of masters and memory.
- DATA_WIDTH, 32, data width of masters and memory.
- READ_LATENCY, 1, cycles from mem_read assertion until mem_read_data is valid (1..7).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- m0_req  in  1  master 0 (Core) request.
- m0_we  in  1  master 0 write (1) / read (0).
- m0_addr  in  ADDR_WIDTH  master 0 address.
- m0_wdata  in  DATA_WIDTH  master 0 write data.
- m0_rdata  out  DATA_WIDTH  master 0 read data, registered.
- m0_ack  out  1  master 0 completion pulse.
- m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack  same as master 0, for master 1 (Controller_Test).
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_address  out  ADDR_WIDTH  memory address.
- mem_write_data  out  DATA_WIDTH  memory write data.
- mem_read_data  in  DATA_WIDTH  memory read data.
- busy  out  1  high whenever the FSM is not in IDLE.
- owner  out  1  index of the current or last granted master.

Behaviour:
- Reset is synchronous and active-low. When reset==0 at a clk edge:
  - FSM goes to IDLE.
  - mem_read, mem_write, m0_ack, m1_ack and busy go to 0.
  - mem_address, mem_write_data, m0_rdata and m1_rdata go to 0.
  - last_grant goes to 1 (so master 0 wins the first tie); owner goes to 0.
- Reset aborts any in-flight transaction. No ack is issued for the aborted transaction.
- Handshake:
  - A master raises req with we/addr/wdata valid and holds them until its ack.
  - ack is a single-cycle pulse.
  - If req is still high in the cycle after ack, it is a new request.
  - If req drops before ack, the transaction still completes and ack still pulses; abort is not supported.
- FSM states:
  - IDLE -> GRANT when any req is high.
  - GRANT -> ACCESS always.
  - ACCESS -> DONE on a write.
  - ACCESS -> WAIT on a read.
  - WAIT -> DONE when the latency counter reaches READ_LATENCY-1.
  - DONE -> IDLE always.
- Arbitration (evaluated in IDLE):
  - Only one req high: that master wins.
  - Both high: the master != last_grant wins.
  - Winner latched into owner and last_grant; its we/addr/wdata latched into mem_address, mem_write_data and an internal we register.
  - Masters' inputs are ignored after latching.
- Strobes:
  - mem_read or mem_write is high only during the single ACCESS cycle.
  - Never both high; never high outside ACCESS.
- Read capture: on the edge ending the final WAIT cycle, mem_read_data is registered into the owner's rdata. The other master's rdata is unchanged.
- Ack: the owner's ack is high during DONE. The other ack stays 0.
- Latency (first req seen in IDLE at cycle N):
  - Write: ACCESS at N+2, ack at N+3.
  - Read: ACCESS at N+2, ack at N+3+READ_LATENCY.
  - Next arbitration happens in IDLE at ack+1.
- rdata holds its value until that master's next read completes.
- busy is 0 only in IDLE.
- Latency counter is 3 bits and resets to 0 on entering WAIT.
- Simultaneous new req from the losing master while a transaction is in flight: it waits and is served at the next IDLE, so starvation is impossible.

Test Plan:
- Reset held low 3 cycles mid-read (state WAIT) -> strobes/acks 0, state IDLE, no ack pulse afterwards, rdata = 0.
- m0 write addr 0x10 data 0xDEADBEEF at N -> mem_write=1, mem_address=0x10 at N+2 only; m0_ack pulse at N+3; m1_ack stays 0.
- m1 read addr 0x10 after that write (READ_LATENCY=1) -> mem_read at N+2, m1_rdata=0xDEADBEEF and m1_ack at N+4; m0_rdata unchanged.
- Both req high from reset, held continuously -> grant order m0, m1, m0, m1; each ack exactly one cycle; owner toggles.
- m0 drops req one cycle after grant -> transaction completes, m0_ack still pulses once.
- READ_LATENCY=3, m0 read -> mem_read high exactly one cycle, m0_ack at N+6, data equals memory content at that address.
